// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake plus the mem8 data-memory port of mem_access_ctrl.
// slave: the controller side; master: the CPU core / memory side.
interface mem_access_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_rt;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic [1:0]        resp_err;
    logic [ADDR_W-1:0] badvaddr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_mask;
    logic              mem_signed_ext;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_op, req_addr, req_rt, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, badvaddr,
               mem_we, mem_addr, mem_mask, mem_signed_ext, mem_wdata
    );

    modport master (
        output req_valid, req_op, req_addr, req_rt, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, badvaddr,
               mem_we, mem_addr, mem_mask, mem_signed_ext, mem_wdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the CPU MEM stage and the mem8 data memory.
// Define MEMCTL_UNALIGNED_LR_EN to enable LWL/LWR/SWL/SWR (ops 8-11) and the MERGE state.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W = 32
) (
    input logic               clk,
    input logic               rst_n,
    mem_access_ctrl_if.slave  bus_io
);
    localparam logic [3:0] OpLb  = 4'd0;
    localparam logic [3:0] OpLbu = 4'd1;
    localparam logic [3:0] OpLh  = 4'd2;
    localparam logic [3:0] OpLhu = 4'd3;
    localparam logic [3:0] OpLw  = 4'd4;
    localparam logic [3:0] OpSb  = 4'd5;
    localparam logic [3:0] OpSh  = 4'd6;
    localparam logic [3:0] OpSw  = 4'd7;
`ifdef MEMCTL_UNALIGNED_LR_EN
    localparam logic [3:0] OpLwl = 4'd8;
    localparam logic [3:0] OpLwr = 4'd9;
    localparam logic [3:0] OpSwl = 4'd10;
    localparam logic [3:0] OpSwr = 4'd11;
`endif

    localparam logic [1:0] ErrNone = 2'd0;
    localparam logic [1:0] ErrAdel = 2'd1;
    localparam logic [1:0] ErrAdes = 2'd2;
    localparam logic [1:0] ErrIll  = 2'd3;

`ifdef MEMCTL_UNALIGNED_LR_EN
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StMerge  = 2'd2,
        StResp   = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd3
    } state_e;
`endif

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       rt_q, rt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        err_q, err_d;
    logic [ADDR_W-1:0] bad_q, bad_d;

    logic req_illegal, req_misaligned, req_store;

    function automatic logic [1:0] op_size(input logic [3:0] op);
        case (op)
            OpLh, OpLhu, OpSh: return 2'b01;
            OpLw, OpSw:        return 2'b10;
            default:           return 2'b00;
        endcase
    endfunction

`ifdef MEMCTL_UNALIGNED_LR_EN
    logic [31:0]       word_q, word_d;
    logic [ADDR_W-1:0] addr_aligned;
    logic [1:0]        byte_n;

    assign addr_aligned = {addr_q[ADDR_W-1:2], 2'b00};
    assign byte_n       = addr_q[1:0];

    // Merges follow little-endian byte numbering: n selects the boundary byte.
    function automatic logic [31:0] lwl_merge(input logic [31:0] w, input logic [31:0] rt,
                                              input logic [1:0] n);
        case (n)
            2'd0:    return {w[7:0], rt[23:0]};
            2'd1:    return {w[15:0], rt[15:0]};
            2'd2:    return {w[23:0], rt[7:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] lwr_merge(input logic [31:0] w, input logic [31:0] rt,
                                              input logic [1:0] n);
        case (n)
            2'd0:    return w;
            2'd1:    return {rt[31:24], w[31:8]};
            2'd2:    return {rt[31:16], w[31:16]};
            default: return {rt[31:8], w[31:24]};
        endcase
    endfunction

    function automatic logic [31:0] swl_merge(input logic [31:0] w, input logic [31:0] rt,
                                              input logic [1:0] n);
        case (n)
            2'd0:    return {w[31:8], rt[31:24]};
            2'd1:    return {w[31:16], rt[31:16]};
            2'd2:    return {w[31:24], rt[31:8]};
            default: return rt;
        endcase
    endfunction

    function automatic logic [31:0] swr_merge(input logic [31:0] w, input logic [31:0] rt,
                                              input logic [1:0] n);
        case (n)
            2'd0:    return rt;
            2'd1:    return {rt[23:0], w[7:0]};
            2'd2:    return {rt[15:0], w[15:0]};
            default: return {rt[7:0], w[23:0]};
        endcase
    endfunction
`endif

    always_comb begin
        req_store      = 1'b0;
        req_misaligned = 1'b0;
`ifdef MEMCTL_UNALIGNED_LR_EN
        req_illegal    = (bus_io.req_op > 4'd11);
`else
        req_illegal    = (bus_io.req_op > 4'd7);
`endif
        case (bus_io.req_op)
            OpSb:       req_store = 1'b1;
            OpSh:       req_store = 1'b1;
            OpSw:       req_store = 1'b1;
            4'd10:      req_store = 1'b1;
            4'd11:      req_store = 1'b1;
            default:    req_store = 1'b0;
        endcase
        case (bus_io.req_op)
            OpLh, OpLhu, OpSh: req_misaligned = bus_io.req_addr[0];
            OpLw, OpSw:        req_misaligned = (bus_io.req_addr[1:0] != 2'b00);
            default:           req_misaligned = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= 4'd0;
            addr_q  <= '0;
            rt_q    <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= ErrNone;
            bad_q   <= '0;
`ifdef MEMCTL_UNALIGNED_LR_EN
            word_q  <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            rt_q    <= rt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            bad_q   <= bad_d;
`ifdef MEMCTL_UNALIGNED_LR_EN
            word_q  <= word_d;
`endif
        end
    end

    // Response registers only change on the edge entering RESP, so they hold in between.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        rt_d    = rt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        bad_d   = bad_q;
`ifdef MEMCTL_UNALIGNED_LR_EN
        word_d  = word_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus_io.req_valid) begin
                    op_d   = bus_io.req_op;
                    addr_d = bus_io.req_addr;
                    rt_d   = bus_io.req_rt;
                    if (req_illegal || req_misaligned) begin
                        state_d = StResp;
                        rdata_d = 32'd0;
                        bad_d   = bus_io.req_addr;
                        err_d   = req_illegal ? ErrIll : (req_store ? ErrAdes : ErrAdel);
                    end else begin
                        state_d = StAccess;
                    end
                end
            end
            StAccess: begin
                state_d = StResp;
                err_d   = ErrNone;
                bad_d   = '0;
                rdata_d = (op_q <= OpLw) ? bus_io.mem_rdata : 32'd0;
`ifdef MEMCTL_UNALIGNED_LR_EN
                case (op_q)
                    OpLwl: rdata_d = lwl_merge(bus_io.mem_rdata, rt_q, byte_n);
                    OpLwr: rdata_d = lwr_merge(bus_io.mem_rdata, rt_q, byte_n);
                    OpSwl, OpSwr: begin
                        word_d  = bus_io.mem_rdata;
                        state_d = StMerge;
                        err_d   = err_q;
                        bad_d   = bad_q;
                        rdata_d = rdata_q;
                    end
                    default: ;
                endcase
`endif
            end
`ifdef MEMCTL_UNALIGNED_LR_EN
            StMerge: begin
                state_d = StResp;
                err_d   = ErrNone;
                bad_d   = '0;
                rdata_d = 32'd0;
            end
`endif
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus_io.req_ready      = 1'b0;
        bus_io.resp_valid     = 1'b0;
        bus_io.mem_we         = 1'b0;
        bus_io.mem_addr       = '0;
        bus_io.mem_mask       = 2'b00;
        bus_io.mem_signed_ext = 1'b0;
        bus_io.mem_wdata      = 32'd0;
        unique case (state_q)
            StIdle: bus_io.req_ready = 1'b1;
            StAccess: begin
`ifdef MEMCTL_UNALIGNED_LR_EN
                if (op_q >= OpLwl) begin
                    bus_io.mem_addr = addr_aligned;
                    bus_io.mem_mask = 2'b10;
                end else
`endif
                begin
                    bus_io.mem_addr       = addr_q;
                    bus_io.mem_mask       = op_size(op_q);
                    bus_io.mem_signed_ext = (op_q == OpLb) || (op_q == OpLh);
                    if (op_q >= OpSb) begin
                        bus_io.mem_we    = 1'b1;
                        bus_io.mem_wdata = rt_q;
                    end
                end
            end
`ifdef MEMCTL_UNALIGNED_LR_EN
            StMerge: begin
                bus_io.mem_we    = 1'b1;
                bus_io.mem_addr  = addr_aligned;
                bus_io.mem_mask  = 2'b10;
                bus_io.mem_wdata = (op_q == OpSwl) ? swl_merge(word_q, rt_q, byte_n)
                                                   : swr_merge(word_q, rt_q, byte_n);
            end
`endif
            StResp:  bus_io.resp_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus_io.resp_rdata = rdata_q;
    assign bus_io.resp_err   = err_q;
    assign bus_io.badvaddr   = bad_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: byte-array memory, byte-level reference model and per-cycle monitor.
module tb_mem_access_ctrl;
    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
    mem_access_ctrl #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus_io(bus));

    logic [7:0] mem     [0:1023];
    logic [7:0] ref_mem [0:1023];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [9:0] ma;
    always_comb begin
        ma = bus.mem_addr[9:0];
        case (bus.mem_mask)
            2'b00:   bus.mem_rdata = {{24{bus.mem_signed_ext & mem[ma][7]}}, mem[ma]};
            2'b01:   bus.mem_rdata = {{16{bus.mem_signed_ext & mem[ma+10'd1][7]}},
                                      mem[ma+10'd1], mem[ma]};
            default: bus.mem_rdata = {mem[ma+10'd3], mem[ma+10'd2], mem[ma+10'd1], mem[ma]};
        endcase
    end

    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[ma] <= bus.mem_wdata[7:0];
            if (bus.mem_mask != 2'b00) mem[ma+10'd1] <= bus.mem_wdata[15:8];
            if (bus.mem_mask == 2'b10) begin
                mem[ma+10'd2] <= bus.mem_wdata[23:16];
                mem[ma+10'd3] <= bus.mem_wdata[31:24];
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_word(input logic [31:0] a);
        logic [9:0] b;
        b = {a[9:2], 2'b00};
        return {mem[b+10'd3], mem[b+10'd2], mem[b+10'd1], mem[b]};
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [9:0] b;
        b = {a[9:2], 2'b00};
        return {ref_mem[b+10'd3], ref_mem[b+10'd2], ref_mem[b+10'd1], ref_mem[b]};
    endfunction

    // Expected-behaviour bookkeeping shared with the monitor.
    int          acc_cyc = -10, resp_cyc = -10, we_cyc = -10;
    logic [31:0] exp_rdata = 0, exp_bad = 0, hold_rdata = 0, hold_bad = 0;
    logic [1:0]  exp_err = 0, hold_err = 0;
    logic        mon_en = 1'b0;
    logic        busy;

    always @(negedge clk) begin
        if (mon_en) begin
            busy = (cyc > acc_cyc) && (cyc <= resp_cyc);
            check("req_ready", {31'd0, bus.req_ready}, {31'd0, !busy});
            check("resp_valid", {31'd0, bus.resp_valid}, {31'd0, cyc == resp_cyc});
            check("mem_we", {31'd0, bus.mem_we}, {31'd0, cyc == we_cyc});
            if (cyc == resp_cyc) begin
                hold_rdata = exp_rdata;
                hold_err   = exp_err;
                hold_bad   = exp_bad;
            end
            check("resp_rdata", bus.resp_rdata, hold_rdata);
            check("resp_err", {30'd0, bus.resp_err}, {30'd0, hold_err});
            if (hold_err != 2'd0) check("badvaddr", bus.badvaddr, hold_bad);
        end
    end

    // Reference: latency, write cycle offset, error and result from byte-level rules.
    task automatic model(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt,
                         output int lat, output int weo, output logic [1:0] err,
                         output logic [31:0] rd);
        logic [9:0] a, b;
        int         n;
        logic [7:0] w [4];
        logic [7:0] rb [4];
        logic [7:0] res [4];
        logic       legal, store, misal;
        a = addr[9:0];
        b = {addr[9:2], 2'b00};
        n = int'(addr[1:0]);
        for (int i = 0; i < 4; i++) begin
            w[i]  = ref_mem[b+10'(i)];
            rb[i] = rt[8*i +: 8];
            res[i] = rb[i];
        end
        lat = 2; weo = 0; err = 2'd0; rd = 32'd0;
        legal = (op < 4'd12);
`ifndef MEMCTL_UNALIGNED_LR_EN
        if (op >= 4'd8) legal = 1'b0;
`endif
        store = (op == 4'd5) || (op == 4'd6) || (op == 4'd7) || (op == 4'd10) || (op == 4'd11);
        misal = ((op == 4'd2 || op == 4'd3 || op == 4'd6) && addr[0]) ||
                ((op == 4'd4 || op == 4'd7) && addr[1:0] != 2'b00);
        if (!legal) begin
            err = 2'd3; lat = 1; return;
        end
        if (misal) begin
            err = store ? 2'd2 : 2'd1; lat = 1; return;
        end
        case (op)
            4'd0: rd = {{24{ref_mem[a][7]}}, ref_mem[a]};
            4'd1: rd = {24'd0, ref_mem[a]};
            4'd2: rd = {{16{ref_mem[a+10'd1][7]}}, ref_mem[a+10'd1], ref_mem[a]};
            4'd3: rd = {16'd0, ref_mem[a+10'd1], ref_mem[a]};
            4'd4: rd = {w[3], w[2], w[1], w[0]};
            4'd5: begin ref_mem[a] = rb[0]; weo = 1; end
            4'd6: begin ref_mem[a] = rb[0]; ref_mem[a+10'd1] = rb[1]; weo = 1; end
            4'd7: begin
                for (int i = 0; i < 4; i++) ref_mem[b+10'(i)] = rb[i];
                weo = 1;
            end
            4'd8: begin
                for (int j = 0; j <= n; j++) res[3-n+j] = w[j];
                rd = {res[3], res[2], res[1], res[0]};
            end
            4'd9: begin
                for (int j = 0; j <= 3 - n; j++) res[j] = w[n+j];
                rd = {res[3], res[2], res[1], res[0]};
            end
            4'd10: begin
                for (int j = 0; j <= n; j++) ref_mem[b+10'(j)] = rb[3-n+j];
                lat = 3; weo = 2;
            end
            default: begin
                for (int j = 0; j <= 3 - n; j++) ref_mem[b+10'(n+j)] = rb[j];
                lat = 3; weo = 2;
            end
        endcase
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt);
        int          lat, weo;
        logic [1:0]  e;
        logic [31:0] rd;
        @(negedge clk);
        model(op, addr, rt, lat, weo, e, rd);
        exp_rdata = rd;
        exp_err   = e;
        exp_bad   = addr;
        acc_cyc   = cyc;
        resp_cyc  = cyc + lat;
        we_cyc    = (weo != 0) ? cyc + weo : -10;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_rt    = rt;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_op    = 4'hF;
        bus.req_rt    = 32'h5A5A_5A5A;
        while (cyc <= resp_cyc) @(negedge clk);
        check("mem_word", dut_word(addr), ref_word(addr));
    endtask

    logic [31:0] saved;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 8'(i * 37 + 5);
            ref_mem[i] = 8'(i * 37 + 5);
        end
        bus.req_valid = 1'b0;
        bus.req_op    = 4'd0;
        bus.req_addr  = 32'd0;
        bus.req_rt    = 32'd0;
        #1;
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_resp_err", {30'd0, bus.resp_err}, 32'd0);
        check("rst_badvaddr", bus.badvaddr, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_mask", {30'd0, bus.mem_mask}, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        do_op(4'd7, 32'h200, 32'h4433_2211);
        check("sw_lit", dut_word(32'h200), 32'h4433_2211);
        do_op(4'd5, 32'h101, 32'h0000_00AB);
        do_op(4'd0, 32'h101, 32'h0);
        check("lb_lit", bus.resp_rdata, 32'hFFFF_FFAB);
        do_op(4'd1, 32'h101, 32'h0);
        check("lbu_lit", bus.resp_rdata, 32'h0000_00AB);
        do_op(4'd4, 32'h102, 32'h0);
        check("lw_adel_lit", {30'd0, bus.resp_err}, 32'd1);
        check("lw_bad_lit", bus.badvaddr, 32'h102);
        do_op(4'd6, 32'h103, 32'h1234);
        check("sh_ades_lit", {30'd0, bus.resp_err}, 32'd2);
        do_op(4'd13, 32'h0, 32'h0);
        check("illegal_lit", {30'd0, bus.resp_err}, 32'd3);

        do_op(4'd8, 32'h201, 32'hAABB_CCDD);
`ifdef MEMCTL_UNALIGNED_LR_EN
        check("lwl_lit", bus.resp_rdata, 32'h2211_CCDD);
`else
        check("lwl_ill_lit", {30'd0, bus.resp_err}, 32'd3);
`endif
        do_op(4'd9, 32'h201, 32'hAABB_CCDD);
`ifdef MEMCTL_UNALIGNED_LR_EN
        check("lwr_lit", bus.resp_rdata, 32'hAA44_3322);
`endif
        do_op(4'd10, 32'h201, 32'hAABB_CCDD);
`ifdef MEMCTL_UNALIGNED_LR_EN
        check("swl_lit", dut_word(32'h200), 32'h4433_AABB);
`else
        check("swl_nowrite_lit", dut_word(32'h200), 32'h4433_2211);
`endif
        do_op(4'd7, 32'h200, 32'h4433_2211);
        do_op(4'd11, 32'h202, 32'hAABB_CCDD);
`ifdef MEMCTL_UNALIGNED_LR_EN
        check("swr_lit", dut_word(32'h200), 32'hCCDD_2211);
`endif

        // Every plain op at every byte offset, then every LR op at every offset.
        for (int op = 0; op < 8; op++)
            for (int n = 0; n < 4; n++)
                do_op(4'(op), 32'h180 + 32'(n), 32'h8765_4321 + 32'(op * 16 + n));
        for (int op = 8; op < 12; op++)
            for (int n = 0; n < 4; n++)
                do_op(4'(op), 32'h240 + 32'(n), 32'h1020_3040 + 32'(n) * 32'h0101_0101);
        do_op(4'd15, 32'h55, 32'h0);

        // Reset during the ACCESS cycle of a SW must suppress the write.
        @(negedge clk);
        mon_en = 1'b0;
        saved = dut_word(32'h300);
        bus.req_valid = 1'b1;
        bus.req_op    = 4'd7;
        bus.req_addr  = 32'h300;
        bus.req_rt    = 32'hDEAD_BEEF;
        @(posedge clk);
        #2;
        check("sw_access_we", {31'd0, bus.mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_mem_we", {31'd0, bus.mem_we}, 32'd0);
        check("abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("abort_mem_addr", bus.mem_addr, 32'd0);
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("abort_no_write", dut_word(32'h300), saved);
        @(negedge clk);
        rst_n = 1'b1;
        acc_cyc = -10; resp_cyc = -10; we_cyc = -10;
        hold_rdata = 0; hold_err = 0; hold_bad = 0;
        @(negedge clk);
        check("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
        mon_en = 1'b1;
        do_op(4'd4, 32'h300, 32'h0);
        check("post_rst_lw", bus.resp_rdata, saved);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
